// File: rtl/onchip_arb_pkg.sv
// onchip_arb_pkg: shared types and defaults for the on-chip RAM arbiter (arbiter state encoding, bus widths, owner indices).
package onchip_arb_pkg;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;
  localparam int MAX_GRANT_DEF = 4;
  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;
endpackage

// File: rtl/onchip_arb_rr.sv
// onchip_arb_rr: 2-way round-robin arbiter with bounded ownership runs.
// Ports: clk, reset_n (async active-low), req[1:0] requests in, gnt[1:0] one-hot-or-zero grant out (combinational).
module onchip_arb_rr
  import onchip_arb_pkg::*;
#(
  parameter int MAX_GRANT = MAX_GRANT_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  localparam logic [3:0] MAX_G = 4'(MAX_GRANT);
  arb_state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       last, last_nx, cur, stay, sel;
  // The current owner keeps the port while it requests, unless the other side
  // is waiting and the owner has already used its full run.
  assign cur  = (state == OWN1);
  assign stay = (state != IDLE) && req[cur] && (!req[!cur] || cnt < MAX_G);
  always_comb begin
    gnt      = '0;
    state_nx = IDLE;
    cnt_nx   = cnt;
    last_nx  = last;
    sel      = (state == IDLE) ? ((req == 2'b11) ? !last : req[1]) : (stay ? cur : !cur);
    if (req[sel]) begin
      gnt[sel] = 1'b1;
      state_nx = sel ? OWN1 : OWN0;
      last_nx  = sel;
      cnt_nx   = stay ? ((cnt == 4'hF) ? cnt : cnt + 4'd1) : 4'd1;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      last  <= last_nx;
    end
  end
endmodule

// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: shares a single-port on-chip RAM between two Avalon-MM masters (m0 CPU, m1 DMA).
// Ports: clk, reset_n (async active-low); per master mN_address/byteenable/read/write/writedata in,
// mN_waitrequest/readdata/readdatavalid out; RAM side mem_address/byteenable/chipselect/write/writedata out,
// mem_readdata in (1-cycle read latency).
module onchip_mem_arbiter
  import onchip_arb_pkg::*;
#(
  parameter  int ADDR_W    = ADDR_W_DEF,
  parameter  int DATA_W    = DATA_W_DEF,
  parameter  int MAX_GRANT = MAX_GRANT_DEF,
  localparam int BE_W      = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);
  logic [1:0] req, arb_gnt, gnt;
  logic       hit, sel, wr, rd_pend, rd_owner;
  assign req = {m1_read | m1_write, m0_read | m0_write};
  onchip_arb_rr #(.MAX_GRANT(MAX_GRANT)) u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .gnt     (arb_gnt)
  );
  // Nothing is accepted while reset is held, even though the grant logic is combinational.
  assign gnt = arb_gnt & {2{reset_n}};
  assign hit = |gnt;
  assign sel = gnt[1];
  // Write wins over a simultaneous read, so such a request never returns data.
  assign wr             = sel ? m1_write : m0_write;
  assign mem_chipselect = hit;
  assign mem_write      = hit & wr;
  assign mem_address    = hit ? (sel ? m1_address : m0_address) : '0;
  assign mem_byteenable = hit ? (sel ? m1_byteenable : m0_byteenable) : '0;
  assign mem_writedata  = hit ? (sel ? m1_writedata : m0_writedata) : '0;
  assign m0_waitrequest = !gnt[0];
  assign m1_waitrequest = !gnt[1];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend  <= 1'b0;
      rd_owner <= OWNER_M0;
    end else begin
      rd_pend  <= hit & !wr;
      rd_owner <= sel;
    end
  end
  assign m0_readdatavalid = rd_pend & (rd_owner == OWNER_M0);
  assign m1_readdatavalid = rd_pend & (rd_owner == OWNER_M1);
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
endmodule
